// File: rtl/clk_div_core.sv
// Programmable integer clock divider with 50% duty for odd and even ratios.
// Ratio changes are deferred to output-period boundaries so clk_o never glitches.
module clk_div_core #(
  parameter int CNT_W   = 8,
  parameter int DIV_DEF = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic             div_vld_i,
  output logic             div_ack_o,
  output logic [CNT_W-1:0] div_cur_o,
  output logic             clk_o,
  output logic             clk_en_o
);

  // state   | meaning
  // ST_IDLE | just out of reset, first edge starts period 0 without counting
  // ST_RUN  | counter cycling 0..N-1
  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam logic [CNT_W-1:0] N_RST = (DIV_DEF < 2) ? CNT_W'(2) : CNT_W'(DIV_DEF);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_pdiv;
  logic             r_pend;
  logic             r_odd;
  logic             r_clk_p;
  logic             r_clk_n;
  logic             r_en;
  logic             r_ack;

  logic             w_run;
  logic             w_wrap;
  logic             w_apply;
  logic [CNT_W-1:0] w_n_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_clamp;
  logic             w_p_nxt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_RUN;
      ST_RUN: begin
        w_run       = 1'b1;
        w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_wrap    = w_run && (r_cnt == (r_n - CNT_W'(1)));
    w_apply   = w_wrap && r_pend;
    w_n_nxt   = w_apply ? r_pdiv : r_n;
    w_cnt_nxt = (!w_run || w_wrap) ? '0 : (r_cnt + CNT_W'(1));
    w_clamp   = (div_i < CNT_W'(2)) ? CNT_W'(2) : div_i;
    w_p_nxt   = (w_cnt_nxt < (w_n_nxt >> 1));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt   <= '0;
      r_n     <= N_RST;
      r_pdiv  <= N_RST;
      r_pend  <= 1'b0;
      r_odd   <= N_RST[0];
      r_clk_p <= 1'b0;
      r_en    <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_clk_p <= w_p_nxt;
      r_en    <= (w_cnt_nxt == '0);
      r_ack   <= w_apply;
      // odd/even select only moves at a boundary, where r_clk_n is known low
      if (w_wrap) begin
        r_n   <= w_n_nxt;
        r_odd <= w_n_nxt[0];
      end
      if (div_vld_i) begin
        r_pdiv <= w_clamp;
        r_pend <= 1'b1;
      end else if (w_apply) begin
        r_pend <= 1'b0;
      end
    end
  end

  // half-cycle extension of the high phase for odd ratios
  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) r_clk_n <= 1'b0;
    else       r_clk_n <= r_clk_p;
  end

  assign clk_o     = r_clk_p | (r_odd & r_clk_n);
  assign clk_en_o  = r_en;
  assign div_ack_o = r_ack;
  assign div_cur_o = r_n;

endmodule
